rr_arbiter_16: RTL and testbench
================================

RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 Parameter: LOCK_EN, default 1, meaning 1 = hold grant until done pulse, 0 = release on acceptance.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 req  input  16  per-requester request level; bit i = requester i.
REQ-005 gnt  output  16  registered grant vector; one-hot when gnt_valid=1, all-zero otherwise; feeds 16-to-4 index encoder.
REQ-006 gnt_valid  output  1  grant offered to downstream.
REQ-007 gnt_ready  input  1  downstream accepts offered grant.
REQ-008 done  input  1  single-cycle pulse ending a locked grant.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 err_done  output  1  sticky flag: done seen outside HOLD.

Function
REQ-011 FSM states SHALL be IDLE, OFFER, HOLD; reset state IDLE.
REQ-012 IDLE: if req != 0 at a rising edge, SHALL load gnt with the one-hot winner, assert gnt_valid, go to OFFER; else remain with gnt=0.
REQ-013 Winner SHALL be the first set req bit searching ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod-16 wrap).
REQ-014 Grant latency SHALL be exactly one cycle: req sampled in IDLE at edge N -> gnt_valid=1 after edge N.
REQ-015 OFFER: gnt and gnt_valid SHALL hold stable until gnt_ready=1, even if the winning req bit drops (no revocation).
REQ-016 OFFER with gnt_ready=1: ptr SHALL become (winner index + 1) mod 16 (15 -> 0); gnt_valid SHALL drop next cycle.
REQ-017 OFFER accept with LOCK_EN=1: go to HOLD, gnt held, gnt_valid=0.
REQ-018 OFFER accept with LOCK_EN=0: go to IDLE, gnt=0; next arbitration on the following edge (minimum one idle cycle between grants).
REQ-019 HOLD: remain until done=1; on done go to IDLE with gnt=0 next cycle.
REQ-020 done in IDLE or OFFER SHALL be ignored for state and SHALL set err_done; err_done clears only on reset.
REQ-021 req changes during OFFER/HOLD SHALL NOT affect gnt or ptr.
REQ-022 gnt SHALL never have more than one bit set in any cycle.
REQ-023 busy SHALL equal (state != IDLE), combinationally decoded from registered state.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force state=IDLE, gnt=0, gnt_valid=0, ptr=0, err_done=0, busy=0, including mid-OFFER or mid-HOLD.
REQ-025 First arbitration after reset release SHALL occur at the first rising edge with rst_n=1 and req != 0, priority starting at bit 0.

Structure
REQ-026 Shared package rr_arb_pkg SHALL hold N_REQ=16, IDX_W=4, and the state enum (IDLE, OFFER, HOLD).
REQ-027 Rotating-priority search SHALL be a separate combinational sub-module rr_pick (inputs req, ptr; outputs one-hot win, win_idx, any).
REQ-028 ptr SHALL be IDX_W bits; wrap relies on natural 4-bit overflow.

Verification
REQ-029 Reset, req=16'h0001 -> after one edge gnt=16'h0001, gnt_valid=1; ready pulse then done -> ptr=1, gnt=0.
REQ-030 req=16'hFFFF held, ready=1 always, done pulsed each HOLD -> grants 0,1,...,15,0 in order (wrap 15->0).
REQ-031 ptr=15 state, req=16'h8001 -> gnt=16'h8000; next round gnt=16'h0001.
REQ-032 OFFER with gnt=16'h0010, drop req[4], ready=0 for 5 cycles -> gnt stays 16'h0010, gnt_valid=1 throughout.
REQ-033 rst_n low mid-HOLD -> gnt=0, busy=0 same cycle; done in IDLE -> err_done=1, state unchanged.
REQ-034 LOCK_EN=0, req=16'h0003, ready=1 -> gnt sequence 0001, 0000, 0002, 0000, 0001; done never required.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
//   N_REQ   : number of requesters
//   IDX_W   : width of a requester index / rotating priority pointer
//   state_t : arbiter FSM states
package rr_arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage : rr_arb_pkg

// File: rtl/rr_arbiter_16_if.sv
// Handshake bundle between requesters/downstream and the arbiter.
//   req       : per-requester request level
//   gnt       : one-hot grant vector (all-zero when nothing is granted)
//   gnt_valid : grant offered downstream
//   gnt_ready : downstream accepts the offered grant
//   done      : single-cycle pulse ending a locked grant
//   busy      : arbiter not in IDLE
//   err_done  : sticky flag, done seen outside HOLD
// modport slave  : arbiter side (drives grant/status)
// modport master : requester/downstream side (drives req/handshake)
interface rr_arbiter_16_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic             gnt_ready;
  logic             done;
  logic             busy;
  logic             err_done;

  modport slave (
    input  req, gnt_ready, done,
    output gnt, gnt_valid, busy, err_done
  );

  modport master (
    output req, gnt_ready, done,
    input  gnt, gnt_valid, busy, err_done
  );

endinterface : rr_arbiter_16_if

// File: rtl/rr_pick.sv
// Rotating-priority picker (purely combinational).
//   i_req     : request vector
//   i_ptr     : index holding highest priority this round
//   o_win     : one-hot winner (zero when no request)
//   o_win_idx : winner index (don't-care when o_any=0)
//   o_any     : at least one request present
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_win,
  output logic [IDX_W-1:0] o_win_idx,
  output logic             o_any
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;

  // Doubling the vector lets a plain shift perform the mod-16 rotation,
  // so bit 0 of w_rot is requester i_ptr.
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[{1'b0, i_ptr} +: N_REQ];

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_off = '0;
    // Scan from the top down so the lowest set offset is the last write.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  // Natural 4-bit overflow wraps the offset back onto the requester range.
  assign o_win_idx = i_ptr + w_off;
  assign o_any     = |i_req;
  assign o_win     = o_any ? ({{(N_REQ-1){1'b0}}, 1'b1} << o_win_idx) : '0;

endmodule : rr_pick

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with offer/accept handshake and optional lock.
//   LOCK_EN : 1 = grant held after acceptance until done, 0 = released
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : handshake bundle (slave modport)
module rr_arbiter_16
  import rr_arb_pkg::*;
#(
  parameter bit LOCK_EN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  rr_arbiter_16_if.slave bus
);

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic             r_gnt_valid;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_win_idx;
  logic             r_err_done;

  logic [N_REQ-1:0] w_win;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_any;

  rr_pick u_pick (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: every register, including the pointer, is asynchronously reset so
  // arbitration after reset always restarts from requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_ptr       <= '0;
      r_win_idx   <= '0;
      r_err_done  <= 1'b0;
    end else begin
      // done is only legal while a locked grant is held.
      if (bus.done && (r_state != HOLD)) r_err_done <= 1'b1;

      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt       <= w_win;
            r_win_idx   <= w_win_idx;
            r_gnt_valid <= 1'b1;
            r_state     <= OFFER;
          end
        end
        OFFER: begin
          // The offer is never revoked; req is not looked at here.
          if (bus.gnt_ready) begin
            r_ptr       <= r_win_idx + 1'b1;
            r_gnt_valid <= 1'b0;
            if (LOCK_EN) begin
              r_state <= HOLD;
            end else begin
              r_gnt   <= '0;
              r_state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (bus.done) begin
            r_gnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.err_done  = r_err_done;
  assign bus.busy      = (r_state != IDLE);

endmodule : rr_arbiter_16

// File: tb/tb_rr_arbiter_16.sv
// Directed self-checking bench: one locked and one unlocked arbiter instance.
module tb_rr_arbiter_16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rr_arbiter_16_if bus_l ();
  rr_arbiter_16_if bus_u ();

  rr_arbiter_16 #(.LOCK_EN(1'b1)) u_dut_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l.slave)
  );

  rr_arbiter_16 #(.LOCK_EN(1'b0)) u_dut_nolock (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_u.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full locked grant: IDLE->OFFER, accept, done.
  task automatic locked_round(input string tag, input logic [15:0] exp);
    bus_l.gnt_ready = 1'b0;
    step();
    check16({tag, "_gnt"}, bus_l.gnt, exp);
    check1({tag, "_valid"}, bus_l.gnt_valid, 1'b1);
    bus_l.gnt_ready = 1'b1;
    step();
    bus_l.gnt_ready = 1'b0;
    bus_l.done = 1'b1;
    step();
    bus_l.done = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_l.req = '0; bus_l.gnt_ready = 1'b0; bus_l.done = 1'b0;
    bus_u.req = '0; bus_u.gnt_ready = 1'b0; bus_u.done = 1'b0;

    // Reset state
    step();
    step();
    check16("rst_gnt", bus_l.gnt, 16'h0000);
    check1("rst_valid", bus_l.gnt_valid, 1'b0);
    check1("rst_busy", bus_l.busy, 1'b0);
    check1("rst_err", bus_l.err_done, 1'b0);
    check16("rst_gnt_u", bus_u.gnt, 16'h0000);
    rst_n = 1'b1;
    step();
    check16("idle_no_req", bus_l.gnt, 16'h0000);
    check1("idle_no_req_busy", bus_l.busy, 1'b0);

    // Single requester 0: one-cycle latency, lock, done
    bus_l.req = 16'h0001;
    step();
    check16("r0_gnt", bus_l.gnt, 16'h0001);
    check1("r0_valid", bus_l.gnt_valid, 1'b1);
    check1("r0_busy", bus_l.busy, 1'b1);
    bus_l.req = 16'h0000;
    bus_l.gnt_ready = 1'b1;
    step();
    check16("r0_hold_gnt", bus_l.gnt, 16'h0001);
    check1("r0_hold_valid", bus_l.gnt_valid, 1'b0);
    check1("r0_hold_busy", bus_l.busy, 1'b1);
    bus_l.gnt_ready = 1'b0;
    step();
    check16("r0_hold_wait", bus_l.gnt, 16'h0001);
    bus_l.done = 1'b1;
    step();
    bus_l.done = 1'b0;
    check16("r0_done_gnt", bus_l.gnt, 16'h0000);
    check1("r0_done_busy", bus_l.busy, 1'b0);
    // ptr is now 1, so requester 1 beats requester 0
    bus_l.req = 16'h0003;
    locked_round("ptr1", 16'h0002);

    // Reset restarts priority at bit 0; full rotation with wrap
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus_l.req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      logic [15:0] e;
      e = 16'h0001 << k[3:0];
      locked_round($sformatf("rot%0d", k), e);
    end
    check1("done_in_hold_no_err", bus_l.err_done, 1'b0);

    // Reach ptr=15, then 15 wins over 0, then 0 next round
    bus_l.req = 16'h4000;
    locked_round("to_ptr15", 16'h4000);
    bus_l.req = 16'h8001;
    locked_round("ptr15_win", 16'h8000);
    locked_round("wrap_win", 16'h0001);

    // No revocation during OFFER; req changes ignored in OFFER and HOLD
    bus_l.req = 16'h0010;
    step();
    check16("offer4_gnt", bus_l.gnt, 16'h0010);
    bus_l.req = 16'h0100;
    for (int k = 0; k < 5; k++) begin
      step();
      check16($sformatf("stall%0d_gnt", k), bus_l.gnt, 16'h0010);
      check1($sformatf("stall%0d_valid", k), bus_l.gnt_valid, 1'b1);
    end
    bus_l.gnt_ready = 1'b1;
    step();
    bus_l.gnt_ready = 1'b0;
    bus_l.req = 16'hFFFF;
    check16("hold4_gnt", bus_l.gnt, 16'h0010);
    check1("hold4_valid", bus_l.gnt_valid, 1'b0);
    step();
    step();
    check16("hold4_req_change", bus_l.gnt, 16'h0010);

    // Asynchronous reset mid-HOLD takes effect before the next edge
    #1;
    rst_n = 1'b0;
    #1;
    check16("async_rst_gnt", bus_l.gnt, 16'h0000);
    check1("async_rst_busy", bus_l.busy, 1'b0);
    check1("async_rst_valid", bus_l.gnt_valid, 1'b0);
    step();
    rst_n = 1'b1;
    bus_l.req = 16'h0000;
    // done in IDLE: sticky error, state stays IDLE
    bus_l.done = 1'b1;
    step();
    bus_l.done = 1'b0;
    check1("err_idle_set", bus_l.err_done, 1'b1);
    check1("err_idle_busy", bus_l.busy, 1'b0);
    check16("err_idle_gnt", bus_l.gnt, 16'h0000);
    step();
    check1("err_sticky", bus_l.err_done, 1'b1);
    // done in OFFER is ignored for state
    bus_l.req = 16'h0004;
    step();
    bus_l.done = 1'b1;
    step();
    bus_l.done = 1'b0;
    check16("done_offer_gnt", bus_l.gnt, 16'h0004);
    check1("done_offer_valid", bus_l.gnt_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("err_clear_rst", bus_l.err_done, 1'b0);
    step();
    rst_n = 1'b1;
    bus_l.req = 16'h0000;

    // Unlocked instance: release on acceptance, one idle cycle between grants
    bus_u.req = 16'h0003;
    bus_u.gnt_ready = 1'b1;
    step();
    check16("nl_g0", bus_u.gnt, 16'h0001);
    check1("nl_v0", bus_u.gnt_valid, 1'b1);
    step();
    check16("nl_g1", bus_u.gnt, 16'h0000);
    check1("nl_v1", bus_u.gnt_valid, 1'b0);
    check1("nl_busy1", bus_u.busy, 1'b0);
    step();
    check16("nl_g2", bus_u.gnt, 16'h0002);
    check1("nl_v2", bus_u.gnt_valid, 1'b1);
    step();
    check16("nl_g3", bus_u.gnt, 16'h0000);
    step();
    check16("nl_g4", bus_u.gnt, 16'h0001);
    check1("nl_err", bus_u.err_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rr_arbiter_16
